// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter in front of a 128-byte word-read ROM.
// One transaction is in flight at a time: IDLE grants a requester, ISSUE drives
// a single ROM read, RESP presents the word to the owning port until it is taken.
// Out-of-range addresses skip the ROM and return an error response.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req{0,1}_valid/addr      request handshake and byte address (port 0 fetch, port 1 data)
//   req{0,1}_ready           request accepted this cycle (IDLE only, granted port only)
//   rsp{0,1}_valid/ready     response handshake
//   rsp{0,1}_data/err        read word / error flag, held stable while valid
//   rom_addr, rom_enable     ROM read address and enable (enable high only in ISSUE)
//   rom_out                  ROM registered read word, valid the cycle after enable
//
// Configuration:
//   ROM_ARB_ALIGN_CHECK_EN   when defined, addresses with addr[1:0] != 0 are errors too.
module rom_arbiter #(
  parameter int unsigned ROM_MAX_ADDR = 124
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic [31:0] rom_addr,
  output logic        rom_enable,
  input  logic [31:0] rom_out
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] MAX_ADDR = AW'(ROM_MAX_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic          owner;        // port that owns the in-flight transaction
  logic          last_q;       // port granted most recently
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic          rsp_valid_q;
  logic          live_q;       // first RESP cycle of a legal read: word comes straight from rom_out
  logic [DW-1:0] data_q;

  logic          gnt1_c;
  logic          accept_c;
  logic [AW-1:0] acc_addr_c;
  logic          bad_c;
  logic          rsp_ready_c;
  logic [DW-1:0] rsp_data_c;

  // Round-robin grant: a lone requester wins, a tie goes to the port not granted last.
  assign gnt1_c     = req1_valid & (~req0_valid | ~last_q);
  assign accept_c   = (state == IDLE) & (req0_valid | req1_valid);
  assign acc_addr_c = gnt1_c ? req1_addr : req0_addr;

  assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~gnt1_c;
  assign req1_ready = rst_n & (state == IDLE) & gnt1_c;

  // Unsigned full-width range compare, so wrap-around values are errors too.
`ifdef ROM_ARB_ALIGN_CHECK_EN
  assign bad_c = (acc_addr_c > MAX_ADDR) || (acc_addr_c[1:0] != 2'b00);
`else
  assign bad_c = (acc_addr_c > MAX_ADDR);
`endif

  assign rsp_ready_c = owner ? rsp1_ready : rsp0_ready;

  // ROM data lands one cycle after ISSUE; it is captured into data_q to stay stable afterwards.
  assign rsp_data_c = live_q ? rom_out : data_q;

  assign rsp0_valid = rsp_valid_q & ~owner;
  assign rsp1_valid = rsp_valid_q & owner;
  assign rsp0_data  = rsp0_valid ? rsp_data_c : '0;
  assign rsp1_data  = rsp1_valid ? rsp_data_c : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;
  assign rom_addr   = addr_q;

  // Transaction FSM with registered response and ROM controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      live_q      <= 1'b0;
      data_q      <= '0;
      rom_enable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            addr_q <= acc_addr_c;
            owner  <= gnt1_c;
            last_q <= gnt1_c;
            err_q  <= bad_c;
            if (bad_c) begin
              data_q      <= '0;
              live_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rom_enable <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          rom_enable  <= 1'b0;
          rsp_valid_q <= 1'b1;
          live_q      <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (live_q) begin
            data_q <= rom_out;
            live_q <= 1'b0;
          end
          if (rsp_ready_c) begin
            rsp_valid_q <= 1'b0;
            live_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rom_enable  <= 1'b0;
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_rom_arbiter;

`ifdef ROM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, rom_addr;
  logic        rom_enable;
  logic [31:0] rom_out = '0;

  int n_tests = 0;
  int n_fail  = 0;

  rom_arbiter #(.ROM_MAX_ADDR(124)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_out(rom_out)
  );

  always #5 clk = ~clk;

  // ROM contents: byte i holds value i, little-endian word reads.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((a + 32'(k)) % 32'd128);
    return w;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (a > 32'd124) || (ALIGN && (a[1:0] != 2'b00));
  endfunction

  always @(posedge clk) if (rom_enable) rom_out <= rom_word(rom_addr);

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, " req0_ready"}, req0_ready, 1'b0);
    chk1({tag, " req1_ready"}, req1_ready, 1'b0);
    chk1({tag, " rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({tag, " rsp1_valid"}, rsp1_valid, 1'b0);
    chk32({tag, " rsp0_data"}, rsp0_data, 32'h0);
    chk32({tag, " rsp1_data"}, rsp1_data, 32'h0);
    chk1({tag, " rsp0_err"}, rsp0_err, 1'b0);
    chk1({tag, " rsp1_err"}, rsp1_err, 1'b0);
    chk1({tag, " rom_enable"}, rom_enable, 1'b0);
    chk32({tag, " rom_addr"}, rom_addr, 32'h0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero(tag);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          v0;
    logic [31:0] a0;
    bit          v1;
    logic [31:0] a1;
    int          port;
    bit          err;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  // One transaction from IDLE: check grant, latency, payload, ROM usage, then complete it.
  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    bit   got;
    bit   seen_en;
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    req0_valid = v.v0; req0_addr = v.a0;
    req1_valid = v.v1; req1_addr = v.a1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk1({t, " ready0"}, req0_ready, v.port == 0);
    chk1({t, " ready1"}, req1_ready, v.port == 1);
    @(posedge clk);
    lat = 0; got = 1'b0; seen_en = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (v.port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      #1;
      if (rom_enable) seen_en = 1'b1;
      chk1({t, " busy ready"}, req0_ready | req1_ready, 1'b0);
      if ((v.port == 0) ? rsp0_valid : rsp1_valid) got = 1'b1;
    end
    chk32({t, " latency"}, got ? lat : 99, v.lat);
    chk32({t, " data"}, (v.port == 0) ? rsp0_data : rsp1_data, v.data);
    chk1({t, " err"}, (v.port == 0) ? rsp0_err : rsp1_err, v.err);
    chk1({t, " other valid"}, (v.port == 0) ? rsp1_valid : rsp0_valid, 1'b0);
    chk1({t, " rom used"}, seen_en, !v.err);
    if (v.port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 32'($urandom_range(0, 31)) * 32'd4;
      4:          return 32'($urandom_range(0, 124));
      5:          return 32'd125 + 32'($urandom_range(0, 6));
      6:          return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
      default:    return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          g[$];
    logic [31:0] d[$];
    int          cyc;
    bit          got;
    int          lat;
    // random-phase model state
    bit          pend[2];
    logic [31:0] paddr[2];
    bit          rdy[2];
    bit          m_busy;
    int          m_port, m_last, m_age, gp;
    bit          m_err, vis;
    logic [31:0] m_addr, m_data;

    vecs[0] = '{1'b1, 32'd0,   1'b0, 32'd0,         0, 1'b0, 32'h03020100, 2};
    vecs[1] = '{1'b0, 32'd0,   1'b1, 32'd125,       1, 1'b1, 32'h0,        1};
    vecs[2] = '{1'b1, 32'd4,   1'b1, 32'd8,         0, 1'b0, 32'h07060504, 2};
    vecs[3] = '{1'b1, 32'd4,   1'b1, 32'd8,         1, 1'b0, 32'h0B0A0908, 2};
    vecs[4] = '{1'b1, 32'd2,   1'b0, 32'd0,         0, ALIGN, ALIGN ? 32'h0 : 32'h05040302, ALIGN ? 1 : 2};
    vecs[5] = '{1'b0, 32'd0,   1'b1, 32'hFFFF_FFFE, 1, 1'b1, 32'h0,        1};
    vecs[6] = '{1'b1, 32'd124, 1'b0, 32'd0,         0, 1'b0, 32'h7F7E7D7C, 2};
    vecs[7] = '{1'b1, 32'd128, 1'b1, 32'd12,        1, 1'b0, 32'h0F0E0D0C, 2};
    vecs[8] = '{1'b1, 32'd128, 1'b1, 32'd12,        0, 1'b1, 32'h0,        1};
    vecs[9] = '{1'b0, 32'd0,   1'b1, 32'd123,       1, ALIGN, ALIGN ? 32'h0 : 32'h7E7D7C7B, ALIGN ? 1 : 2};

    // Reset state and directed table.
    @(posedge clk);
    apply_reset("reset");
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Both ports valid from reset with ready held: alternating grants.
    apply_reset("reset2");
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 32'd4;
    req1_valid = 1'b1; req1_addr = 32'd8;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc = 0;
    while ((g.size() < 4 || d.size() < 4) && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp0_valid) d.push_back(rsp0_data);
      if (rsp1_valid) d.push_back(rsp1_data);
      cyc++;
    end
    chk1("rr enough grants", g.size() >= 4 && d.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk32($sformatf("rr grant%0d", i), (i < g.size()) ? g[i] : 99, i % 2);
      chk32($sformatf("rr data%0d", i), (i < d.size()) ? d[i] : 32'hDEAD_BEEF,
            (i % 2 == 0) ? 32'h07060504 : 32'h0B0A0908);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Back-pressure on port 0 while port 1 waits.
    apply_reset("reset3");
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 32'd16;
    req1_valid = 1'b1; req1_addr = 32'd20;
    #1;
    chk1("bp ready0", req0_ready, 1'b1);
    chk1("bp ready1", req1_ready, 1'b0);
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      req0_valid = 1'b0;
      #1;
      if (rsp0_valid) got = 1'b1;
    end
    chk32("bp latency", got ? lat : 99, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk1($sformatf("bp hold%0d valid", i), rsp0_valid, 1'b1);
      chk32($sformatf("bp hold%0d data", i), rsp0_data, 32'h13121110);
      chk1($sformatf("bp hold%0d ready1", i), req1_ready, 1'b0);
      chk1($sformatf("bp hold%0d rsp1", i), rsp1_valid, 1'b0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    chk1("bp completion ready1", req1_ready, 1'b0);
    chk1("bp completion valid", rsp0_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk1("bp after valid0", rsp0_valid, 1'b0);
    chk1("bp after ready1", req1_ready, 1'b1);
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      req1_valid = 1'b0;
      #1;
      if (rsp1_valid) got = 1'b1;
    end
    chk32("bp p1 latency", got ? lat : 99, 2);
    chk32("bp p1 data", rsp1_data, 32'h17161514);
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Reset asserted during ISSUE aborts the read; the next tie goes to port 0.
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 32'd0; req1_valid = 1'b0;
    #1;
    chk1("abort ready0", req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("abort in issue", rom_enable, 1'b1);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'd8;
    req1_valid = 1'b1; req1_addr = 32'd12;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("abort");
    rst_n = 1'b1;
    #1;
    chk1("abort tie ready0", req0_ready, 1'b1);
    chk1("abort tie ready1", req1_ready, 1'b0);
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      if (rsp0_valid) got = 1'b1;
    end
    chk32("abort post latency", got ? lat : 99, 2);
    chk32("abort post data", rsp0_data, 32'h0B0A0908);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Randomized traffic against a transaction-level reference model.
    apply_reset("reset4");
    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = '0; paddr[1] = '0;
    m_busy = 1'b0; m_port = 0; m_last = 1; m_age = 0;
    m_err = 1'b0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]  = 1'b1;
          paddr[p] = rand_addr();
        end
        rdy[p] = ($urandom_range(0, 2) != 0);
      end
      req0_valid = pend[0]; req0_addr = paddr[0];
      req1_valid = pend[1]; req1_addr = paddr[1];
      rsp0_ready = rdy[0];  rsp1_ready = rdy[1];
      #1;
      gp = -1;
      if (!m_busy) begin
        if (pend[0] && pend[1]) gp = (m_last == 0) ? 1 : 0;
        else if (pend[0])       gp = 0;
        else if (pend[1])       gp = 1;
      end
      vis = m_busy && (m_age >= (m_err ? 1 : 2));
      chk1($sformatf("rnd%0d ready0", c), req0_ready, gp == 0);
      chk1($sformatf("rnd%0d ready1", c), req1_ready, gp == 1);
      chk1($sformatf("rnd%0d rsp0_valid", c), rsp0_valid, vis && m_port == 0);
      chk1($sformatf("rnd%0d rsp1_valid", c), rsp1_valid, vis && m_port == 1);
      chk1($sformatf("rnd%0d rom_enable", c), rom_enable, m_busy && !m_err && m_age == 1);
      chk32($sformatf("rnd%0d rom_addr", c), rom_addr, m_addr);
      if (vis) begin
        chk32($sformatf("rnd%0d data", c), (m_port == 0) ? rsp0_data : rsp1_data, m_data);
        chk1($sformatf("rnd%0d err", c), (m_port == 0) ? rsp0_err : rsp1_err, m_err);
      end
      if (!m_busy) begin
        if (gp >= 0) begin
          m_busy = 1'b1;
          m_port = gp;
          m_last = gp;
          m_addr = paddr[gp];
          m_err  = is_err(m_addr);
          m_data = m_err ? 32'h0 : rom_word(m_addr);
          m_age  = 1;
          pend[gp] = 1'b0;
        end
      end else if (vis && rdy[m_port]) begin
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter: ROM_MAX_ADDR, 124, highest legal word-read byte address (ROM is 128 bytes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  port 0 (fetch) request valid.
REQ-005 req0_addr  input  32  port 0 byte address.
REQ-006 req0_ready  output  1  port 0 request accepted this cycle.
REQ-007 rsp0_valid / rsp0_ready  output / input  1 / 1  port 0 response handshake.
REQ-008 rsp0_data / rsp0_err  output  32 / 1  port 0 read word / error flag.
REQ-009 req1_*, rsp1_*  same directions and widths as port 0; port 1 (data) requester.
REQ-010 rom_addr  output  32  address to ROM.
REQ-011 rom_enable  output  1  ROM read enable.
REQ-012 rom_out  input  32  ROM registered read word, valid the cycle after the edge sampling rom_enable=1.

Function
REQ-013 FSM states: IDLE, ISSUE, RESP; exactly one transaction in flight.
REQ-014 IDLE: reqN_ready=1 only for the granted port; at most one ready high per cycle; all ready low outside IDLE.
REQ-015 Grant: single valid requester wins; both valid -> the port not granted last wins (round-robin); after reset, port 0 wins the first tie.
REQ-016 Accept edge (valid&ready): latch address and port ID; update the last-granted pointer.
REQ-017 Legal address (addr <= ROM_MAX_ADDR) -> ISSUE; otherwise -> RESP with the error flag set and no ROM access.
REQ-018 ISSUE lasts exactly 1 cycle: rom_enable=1, rom_addr=latched address; then -> RESP.
REQ-019 rom_enable=0 in every non-ISSUE cycle; rom_addr holds the last latched address.
REQ-020 RESP: rspN_valid=1 for the owning port only; rspN_data=rom_out (legal) or 0 (error); rspN_err per REQ-017.
REQ-021 Legal-read latency: rspN_valid rises 2 cycles after the accept edge; error latency is 1 cycle.
REQ-022 RESP holds data, err and valid stable until rspN_ready=1; at that edge -> IDLE.
REQ-023 No new accept occurs in the cycle the response completes; the next grant is evaluated in the following IDLE cycle.
REQ-024 The non-owning port's rsp_valid stays 0; its pending request waits, with valid held and no loss.
REQ-025 Address compare is unsigned and full 32-bit; values above ROM_MAX_ADDR, including wrap-around values such as 0xFFFF_FFFE, are errors.

Reset
REQ-026 rst_n=0 at an edge -> state IDLE, last-granted pointer = port 1 (so port 0 wins the first tie), latched address 0.
REQ-027 Outputs during and after reset: all ready/valid 0, rsp data 0, err 0, rom_enable 0, rom_addr 0.
REQ-028 Reset mid-ISSUE or mid-RESP aborts the transaction with no response; a ROM read already issued is discarded.

Configuration
REQ-029 Macro ROM_ARB_ALIGN_CHECK_EN.
REQ-030 Defined: addresses with addr[1:0] != 0 are treated as errors per REQ-017, in addition to the range check.
REQ-031 Undefined: only the range check applies; unaligned legal addresses read 4 consecutive bytes.

Verification
REQ-032 Port 0 reads addr 0, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, data 0x03020100, err 0.
REQ-033 Both ports valid from reset, addrs 4 and 8, ready held 1 -> grant order 0,1,0,1; data 0x07060504 then 0x0B0A0908.
REQ-034 Port 1 reads addr 125 -> rsp1_valid 1 cycle after accept, err 1, data 0, rom_enable never 1.
REQ-035 rsp0_ready held 0 for 5 cycles -> rsp0_valid and data stable; req1 not accepted until the cycle after completion.
REQ-036 Port 0 reads addr 2 -> err 1 with ROM_ARB_ALIGN_CHECK_EN; data 0x05040302 without it.
REQ-037 rst_n=0 asserted during ISSUE -> next cycle all outputs 0, no rsp_valid; a tie afterwards grants port 0.
